// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the divider/ALU register-file writeback arbiter.
package wb_arb_pkg;

    localparam int WB_WIDTH = 32;
    localparam logic [4:0] REG_X0 = 5'd0;

    typedef struct packed {
        logic                valid;
        logic [4:0]          rd;
        logic [WB_WIDTH-1:0] data;
    } wb_entry_t;

    // Which source owns the register-file write port in a given cycle.
    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_ALU  = 2'd1,
        SEL_BUF  = 2'd2,
        SEL_DIV  = 2'd3
    } wb_sel_e;

endpackage

// File: rtl/div_wb_buf.sv
// Circular buffer of divider results that lost the write port, with WAW squash
// and two newest-match forwarding lookups.
module div_wb_buf
    import wb_arb_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       clear,
    input  logic                       push,
    input  logic [4:0]                 push_rd,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    input  logic                       squash,
    input  logic [4:0]                 squash_rd,
    input  logic [4:0]                 rs1,
    input  logic [4:0]                 rs2,
    output logic                       head_valid,
    output logic [4:0]                 head_rd,
    output logic [WIDTH-1:0]           head_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       hit1,
    output logic                       hit2,
    output logic [WIDTH-1:0]           data1,
    output logic [WIDTH-1:0]           data2
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] valid_r;
    logic [4:0]       rd_r   [DEPTH];
    logic [WIDTH-1:0] data_r [DEPTH];
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] valid_cnt_s;
    logic             hit1_s;
    logic             hit2_s;
    logic [WIDTH-1:0] data1_s;
    logic [WIDTH-1:0] data2_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        logic [PTR_W-1:0] n;
        if (p == PTR_W'(DEPTH - 1)) begin
            n = '0;
        end else begin
            n = p + PTR_W'(1);
        end
        return n;
    endfunction

    // Entry storage, pointers and occupancy; freed slots always carry valid=0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_r  <= '0;
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                rd_r[i]   <= REG_X0;
                data_r[i] <= '0;
            end
        end else if (clear) begin
            valid_r  <= '0;
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= '0;
        end else if (en) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (squash && (rd_r[i] == squash_rd)) begin
                    valid_r[i] <= 1'b0;
                end
            end
            if (pop) begin
                valid_r[rd_ptr_r] <= 1'b0;
                rd_ptr_r          <= ptr_inc(rd_ptr_r);
            end
            // Push after pop so a full-buffer push/pop on the same slot keeps the new entry.
            if (push) begin
                valid_r[wr_ptr_r] <= 1'b1;
                rd_r[wr_ptr_r]    <= push_rd;
                data_r[wr_ptr_r]  <= push_data;
                wr_ptr_r          <= ptr_inc(wr_ptr_r);
            end
            count_r <= count_r + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Count of live (unsquashed) entries.
    always_comb begin
        valid_cnt_s = '0;
        for (int i = 0; i < DEPTH; i++) begin
            valid_cnt_s = valid_cnt_s + CNT_W'(valid_r[i]);
        end
    end

    // Forward lookup: walk head to tail so the newest matching entry wins.
    always_comb begin
        int               idx_v;
        logic [PTR_W-1:0] idx_s;
        hit1_s  = 1'b0;
        hit2_s  = 1'b0;
        data1_s = '0;
        data2_s = '0;
        idx_v   = 0;
        idx_s   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx_v = int'(rd_ptr_r) + i;
            if (idx_v >= DEPTH) begin
                idx_v = idx_v - DEPTH;
            end else begin
                idx_v = idx_v + 0;
            end
            idx_s = PTR_W'(idx_v);
            if ((rs1 != REG_X0) && valid_r[idx_s] && (rd_r[idx_s] == rs1)) begin
                hit1_s  = 1'b1;
                data1_s = data_r[idx_s];
            end else begin
                hit1_s  = hit1_s;
            end
            if ((rs2 != REG_X0) && valid_r[idx_s] && (rd_r[idx_s] == rs2)) begin
                hit2_s  = 1'b1;
                data2_s = data_r[idx_s];
            end else begin
                hit2_s  = hit2_s;
            end
        end
    end

    assign head_valid = valid_r[rd_ptr_r];
    assign head_rd    = rd_r[rd_ptr_r];
    assign head_data  = data_r[rd_ptr_r];
    assign count      = count_r;
    assign full       = (valid_cnt_s == CNT_W'(DEPTH));
    assign hit1       = hit1_s;
    assign hit2       = hit2_s;
    assign data1      = data1_s;
    assign data2      = data2_s;

endmodule

// File: rtl/div_wb_arbiter.sv
// Merges divider completions with the ALU writeback stream onto one register-file
// write port; ALU wins, losing divider results park in div_wb_buf.
module div_wb_arbiter
    import wb_arb_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       clear,
    input  logic                       div_valid,
    input  logic                       div_we,
    input  logic [4:0]                 div_rd,
    input  logic [WIDTH-1:0]           div_data,
    input  logic                       alu_valid,
    input  logic                       alu_we,
    input  logic [4:0]                 alu_rd,
    input  logic [WIDTH-1:0]           alu_data,
    input  logic [4:0]                 fwd_rs1,
    input  logic [4:0]                 fwd_rs2,
    output logic                       fwd_hit1,
    output logic                       fwd_hit2,
    output logic [WIDTH-1:0]           fwd_data1,
    output logic [WIDTH-1:0]           fwd_data2,
    output logic                       wb_we,
    output logic [4:0]                 wb_rd,
    output logic [WIDTH-1:0]           wb_data,
    output logic                       wb_src,
    output logic                       div_full,
    output logic [$clog2(DEPTH+1)-1:0] pending,
    output logic                       err_ovf
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             live_s;
    logic             alu_wr_s;
    logic             div_req_s;
    logic             buf_empty_s;
    logic             pop_s;
    logic             direct_s;
    logic             discard_s;
    logic             room_s;
    logic             want_s;
    logic             push_s;
    logic             ovf_s;
    logic             squash_s;
    wb_sel_e          sel_s;
    logic             head_valid_s;
    logic [4:0]       head_rd_s;
    logic [WIDTH-1:0] head_data_s;
    logic [CNT_W-1:0] count_s;
    logic             full_s;

    logic             wb_we_r;
    logic [4:0]       wb_rd_r;
    logic [WIDTH-1:0] wb_data_r;
    logic             wb_src_r;
    logic             err_ovf_r;

    // Slot arbitration plus push/overflow decisions for the divider result.
    always_comb begin
        live_s      = en & ~clear;
        alu_wr_s    = alu_valid & alu_we & (alu_rd != REG_X0);
        div_req_s   = div_valid & div_we & (div_rd != REG_X0);
        buf_empty_s = (count_s == CNT_W'(0));
        pop_s       = live_s & ~alu_wr_s & ~buf_empty_s;
        direct_s    = live_s & ~alu_wr_s & buf_empty_s & div_req_s;
        // The same-cycle ALU write is younger, so a divider result to the same rd is dead.
        discard_s   = alu_wr_s & (div_rd == alu_rd);
        room_s      = (count_s < CNT_W'(DEPTH)) | pop_s;
        want_s      = live_s & div_req_s & ~direct_s & ~discard_s & ~full_s;
        push_s      = want_s & room_s;
        ovf_s       = live_s & ((div_valid & full_s) | (want_s & ~room_s));
        squash_s    = live_s & alu_wr_s;
        if (!live_s) begin
            sel_s = SEL_NONE;
        end else if (alu_wr_s) begin
            sel_s = SEL_ALU;
        end else if (pop_s) begin
            sel_s = SEL_BUF;
        end else if (direct_s) begin
            sel_s = SEL_DIV;
        end else begin
            sel_s = SEL_NONE;
        end
    end

    // Registered write port and sticky overflow flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_we_r   <= 1'b0;
            wb_rd_r   <= REG_X0;
            wb_data_r <= '0;
            wb_src_r  <= 1'b0;
            err_ovf_r <= 1'b0;
        end else if (clear) begin
            wb_we_r   <= 1'b0;
            err_ovf_r <= 1'b0;
        end else if (!en) begin
            wb_we_r   <= 1'b0;
        end else begin
            case (sel_s)
                SEL_ALU: begin
                    wb_we_r   <= 1'b1;
                    wb_rd_r   <= alu_rd;
                    wb_data_r <= alu_data;
                    wb_src_r  <= 1'b0;
                end
                SEL_BUF: begin
                    // A squashed head still burns the slot, just without a write.
                    wb_we_r   <= head_valid_s;
                    wb_rd_r   <= head_rd_s;
                    wb_data_r <= head_data_s;
                    wb_src_r  <= 1'b1;
                end
                SEL_DIV: begin
                    wb_we_r   <= 1'b1;
                    wb_rd_r   <= div_rd;
                    wb_data_r <= div_data;
                    wb_src_r  <= 1'b1;
                end
                default: begin
                    wb_we_r   <= 1'b0;
                end
            endcase
            if (ovf_s) begin
                err_ovf_r <= 1'b1;
            end
        end
    end

    div_wb_buf #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_buf (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .clear      (clear),
        .push       (push_s),
        .push_rd    (div_rd),
        .push_data  (div_data),
        .pop        (pop_s),
        .squash     (squash_s),
        .squash_rd  (alu_rd),
        .rs1        (fwd_rs1),
        .rs2        (fwd_rs2),
        .head_valid (head_valid_s),
        .head_rd    (head_rd_s),
        .head_data  (head_data_s),
        .count      (count_s),
        .full       (full_s),
        .hit1       (fwd_hit1),
        .hit2       (fwd_hit2),
        .data1      (fwd_data1),
        .data2      (fwd_data2)
    );

    assign wb_we    = wb_we_r;
    assign wb_rd    = wb_rd_r;
    assign wb_data  = wb_data_r;
    assign wb_src   = wb_src_r;
    assign div_full = full_s;
    assign pending  = count_s;
    assign err_ovf  = err_ovf_r;

endmodule

// File: tb/tb_div_wb_arbiter.sv
// Scoreboard bench for div_wb_arbiter: a queue-based reference model predicts the
// write port and buffer-visible outputs; separate monitors compare them.
module tb_div_wb_arbiter;

    localparam int WIDTH = 32;
    localparam int DEPTH = 2;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             en = 1'b0, clear = 1'b0;
    logic             div_valid = 1'b0, div_we = 1'b0;
    logic [4:0]       div_rd = 5'd0;
    logic [WIDTH-1:0] div_data = 32'd0;
    logic             alu_valid = 1'b0, alu_we = 1'b0;
    logic [4:0]       alu_rd = 5'd0;
    logic [WIDTH-1:0] alu_data = 32'd0;
    logic [4:0]       fwd_rs1 = 5'd0, fwd_rs2 = 5'd0;
    logic             fwd_hit1, fwd_hit2;
    logic [WIDTH-1:0] fwd_data1, fwd_data2;
    logic             wb_we, wb_src, div_full, err_ovf;
    logic [4:0]       wb_rd;
    logic [WIDTH-1:0] wb_data;
    logic [CNT_W-1:0] pending;

    always #5 clk = ~clk;

    div_wb_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .en(en), .clear(clear),
        .div_valid(div_valid), .div_we(div_we), .div_rd(div_rd), .div_data(div_data),
        .alu_valid(alu_valid), .alu_we(alu_we), .alu_rd(alu_rd), .alu_data(alu_data),
        .fwd_rs1(fwd_rs1), .fwd_rs2(fwd_rs2),
        .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2), .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .wb_src(wb_src),
        .div_full(div_full), .pending(pending), .err_ovf(err_ovf)
    );

    typedef struct { logic valid; logic [4:0] rd; logic [31:0] data; } ent_t;
    typedef struct { logic we; logic [4:0] rd; logic [31:0] data; logic src; } wb_exp_t;
    typedef struct { int pend; logic full; logic err; logic hit1; logic hit2;
                     logic [31:0] d1; logic [31:0] d2; } comb_exp_t;

    ent_t      mq[$];
    logic      m_err = 1'b0;
    wb_exp_t   wbq[$];
    comb_exp_t cq[$];
    wb_exp_t   mw;
    comb_exp_t mc;
    int        checks = 0;
    int        passed = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endfunction

    function automatic void fwd(input logic [4:0] rs, output logic hit, output logic [31:0] d);
        hit = 1'b0;
        d   = 32'd0;
        if (rs != 5'd0)
            foreach (mq[i]) if (mq[i].valid && mq[i].rd == rs) begin hit = 1'b1; d = mq[i].data; end
    endfunction

    // Drive one cycle of inputs and predict outputs from the rules of the arbiter.
    task automatic apply(input logic i_en, input logic i_clr,
                         input logic i_dv, input logic i_dwe, input logic [4:0] i_drd, input logic [31:0] i_dd,
                         input logic i_av, input logic i_awe, input logic [4:0] i_ard, input logic [31:0] i_ad,
                         input logic [4:0] i_rs1, input logic [4:0] i_rs2);
        comb_exp_t c;
        wb_exp_t   w;
        int        vcnt;
        logic      alu_wr, dreq, full, direct;
        @(negedge clk);
        en = i_en; clear = i_clr;
        div_valid = i_dv; div_we = i_dwe; div_rd = i_drd; div_data = i_dd;
        alu_valid = i_av; alu_we = i_awe; alu_rd = i_ard; alu_data = i_ad;
        fwd_rs1 = i_rs1; fwd_rs2 = i_rs2;
        vcnt = 0;
        foreach (mq[i]) if (mq[i].valid) vcnt++;
        full   = (vcnt == DEPTH);
        c.pend = mq.size();
        c.full = full;
        c.err  = m_err;
        fwd(i_rs1, c.hit1, c.d1);
        fwd(i_rs2, c.hit2, c.d2);
        cq.push_back(c);
        w = '{1'b0, 5'd0, 32'd0, 1'b0};
        if (i_clr) begin
            mq.delete();
            m_err = 1'b0;
        end else if (i_en) begin
            alu_wr = i_av && i_awe && (i_ard != 5'd0);
            dreq   = i_dv && i_dwe && (i_drd != 5'd0);
            direct = 1'b0;
            if (alu_wr) begin
                w = '{1'b1, i_ard, i_ad, 1'b0};
                foreach (mq[i]) if (mq[i].rd == i_ard) mq[i].valid = 1'b0;
            end else if (mq.size() > 0) begin
                ent_t e;
                e = mq.pop_front();
                w = '{e.valid, e.rd, e.data, 1'b1};
            end else if (dreq) begin
                w = '{1'b1, i_drd, i_dd, 1'b1};
                direct = 1'b1;
            end
            if (i_dv && full) m_err = 1'b1;
            else if (dreq && !direct && !(alu_wr && i_drd == i_ard)) begin
                if (mq.size() < DEPTH) mq.push_back('{1'b1, i_drd, i_dd});
                else m_err = 1'b1;
            end
        end
        wbq.push_back(w);
    endtask

    task automatic idle(input logic [4:0] r1, input logic [4:0] r2);
        apply(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0, r1, r2);
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_wb_we"}, 32'(wb_we), 32'd0);
        chk({tag, "_wb_rd"}, 32'(wb_rd), 32'd0);
        chk({tag, "_wb_data"}, wb_data, 32'd0);
        chk({tag, "_wb_src"}, 32'(wb_src), 32'd0);
        chk({tag, "_pending"}, 32'(pending), 32'd0);
        chk({tag, "_div_full"}, 32'(div_full), 32'd0);
        chk({tag, "_err_ovf"}, 32'(err_ovf), 32'd0);
        chk({tag, "_hit1"}, 32'(fwd_hit1), 32'd0);
        chk({tag, "_hit2"}, 32'(fwd_hit2), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #3;
        rst = 1'b0;
        en = 1'b0; clear = 1'b0; div_valid = 1'b0; alu_valid = 1'b0;
        mq.delete(); m_err = 1'b0; wbq.delete(); cq.delete();
        #1;
        check_zero_outputs("async_rst");
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Write-port monitor: registered outputs, sampled just after the rising edge.
    always @(posedge clk) begin
        #1;
        if (wbq.size() > 0) begin
            mw = wbq.pop_front();
            chk("wb_we", 32'(wb_we), 32'(mw.we));
            if (mw.we) begin
                chk("wb_rd", 32'(wb_rd), 32'(mw.rd));
                chk("wb_data", wb_data, mw.data);
                chk("wb_src", 32'(wb_src), 32'(mw.src));
            end
        end
    end

    // Buffer-state monitor: forwarding, occupancy and error flag mid-cycle.
    always @(negedge clk) begin
        #1;
        if (cq.size() > 0) begin
            mc = cq.pop_front();
            chk("pending", 32'(pending), 32'(mc.pend));
            chk("div_full", 32'(div_full), 32'(mc.full));
            chk("err_ovf", 32'(err_ovf), 32'(mc.err));
            chk("fwd_hit1", 32'(fwd_hit1), 32'(mc.hit1));
            chk("fwd_hit2", 32'(fwd_hit2), 32'(mc.hit2));
            chk("fwd_data1", fwd_data1, mc.d1);
            chk("fwd_data2", fwd_data2, mc.d2);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        check_zero_outputs("reset");
        @(negedge clk);
        rst = 1'b1;

        // Direct divider write into an empty buffer.
        apply(1'b1, 1'b0, 1'b1, 1'b1, 5'd5, 32'h7, 1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        idle(5'd5, 5'd0);
        // Collision: ALU wins, divider result forwarded then drained.
        apply(1'b1, 1'b0, 1'b1, 1'b1, 5'd5, 32'h22, 1'b1, 1'b1, 5'd3, 32'h11, 5'd5, 5'd3);
        idle(5'd5, 5'd0);
        idle(5'd5, 5'd0);
        // WAW squash of a parked result.
        apply(1'b1, 1'b0, 1'b1, 1'b1, 5'd6, 32'h55, 1'b1, 1'b1, 5'd1, 32'h1, 5'd6, 5'd0);
        apply(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 5'd6, 32'hAA, 5'd6, 5'd0);
        idle(5'd6, 5'd0);
        idle(5'd6, 5'd0);
        idle(5'd6, 5'd0);
        // Fill to full under continuous ALU traffic, then overflow.
        for (int k = 0; k < 3; k++)
            apply(1'b1, 1'b0, 1'b1, 1'b1, 5'(7 + k), 32'(32'h100 + k),
                  1'b1, 1'b1, 5'(1 + k), 32'(32'h200 + k), 5'd7, 5'd8);
        for (int k = 0; k < 3; k++) idle(5'd7, 5'd8);
        // rd == 0 from either source.
        apply(1'b1, 1'b0, 1'b1, 1'b1, 5'd0, 32'h99, 1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        apply(1'b1, 1'b0, 1'b1, 1'b1, 5'd4, 32'h44, 1'b1, 1'b1, 5'd2, 32'h2, 5'd4, 5'd0);
        apply(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 5'd0, 32'h33, 5'd4, 5'd0);
        idle(5'd4, 5'd0);
        // Async reset with results still pending.
        apply(1'b1, 1'b0, 1'b1, 1'b1, 5'd9, 32'h9, 1'b1, 1'b1, 5'd1, 32'h1, 5'd9, 5'd10);
        apply(1'b1, 1'b0, 1'b1, 1'b1, 5'd10, 32'hA, 1'b1, 1'b1, 5'd2, 32'h2, 5'd9, 5'd10);
        do_reset();
        // Clear mid-drain; same-cycle inputs must be ignored.
        apply(1'b1, 1'b0, 1'b1, 1'b1, 5'd9, 32'h9, 1'b1, 1'b1, 5'd1, 32'h1, 5'd9, 5'd10);
        apply(1'b1, 1'b0, 1'b1, 1'b1, 5'd10, 32'hA, 1'b1, 1'b1, 5'd2, 32'h2, 5'd9, 5'd10);
        apply(1'b1, 1'b0, 1'b1, 1'b1, 5'd11, 32'hB, 1'b1, 1'b1, 5'd3, 32'h3, 5'd9, 5'd10);
        idle(5'd9, 5'd10);
        apply(1'b1, 1'b1, 1'b1, 1'b1, 5'd12, 32'hC, 1'b1, 1'b1, 5'd4, 32'h4, 5'd9, 5'd10);
        idle(5'd9, 5'd10);
        idle(5'd12, 5'd4);
        // Enable low holds the buffer and blocks writes.
        apply(1'b1, 1'b0, 1'b1, 1'b1, 5'd13, 32'hD, 1'b1, 1'b1, 5'd1, 32'h1, 5'd13, 5'd0);
        apply(1'b0, 1'b0, 1'b1, 1'b1, 5'd14, 32'hE, 1'b1, 1'b1, 5'd13, 32'hF, 5'd13, 5'd0);
        idle(5'd13, 5'd0);
        idle(5'd13, 5'd0);
        // Randomised traffic on a small register set to provoke collisions.
        for (int n = 0; n < 400; n++) begin
            apply(1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 39) == 0),
                  1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 5) != 0),
                  5'($urandom_range(0, 7)), 32'($urandom),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 5) != 0),
                  5'($urandom_range(0, 7)), 32'($urandom),
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        end
        for (int k = 0; k < 4; k++) idle(5'd0, 5'd0);
        @(posedge clk);
        #3;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
